// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector with a run-time loadable pattern, selectable
// overlapping/non-overlapping matching and a saturating match counter.
module seq_det_param #(
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8,
    parameter int FILL_W = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              seq_in,
    input  logic              pat_load,
    input  logic [PAT_W-1:0]  pattern_in,
    input  logic              overlap_mode,
    input  logic              clr_cnt,
    output logic              detected,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              cnt_sat,
    output logic [FILL_W-1:0] state_out
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  pattern_r, pattern_nxt_s;
    logic [PAT_W-1:0]  window_r, window_nxt_s, nxt_win_s;
    logic [FILL_W-1:0] fill_r, fill_nxt_s, nfill_s;
    logic              detected_r;
    logic [CNT_W-1:0]  match_cnt_r, cnt_base_s, cnt_nxt_s;
    logic              cnt_sat_r, cnt_sat_nxt_s;
    logic              hit_s;

    // State registers; every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_r   <= {PAT_W{1'b1}};
            window_r    <= {PAT_W{1'b0}};
            fill_r      <= {FILL_W{1'b0}};
            detected_r  <= 1'b0;
            match_cnt_r <= {CNT_W{1'b0}};
            cnt_sat_r   <= 1'b0;
        end else begin
            pattern_r   <= pattern_nxt_s;
            window_r    <= window_nxt_s;
            fill_r      <= fill_nxt_s;
            detected_r  <= hit_s;
            match_cnt_r <= cnt_nxt_s;
            cnt_sat_r   <= cnt_sat_nxt_s;
        end
    end

    // Next window/fill/pattern and hit detection.
    always_comb begin
        nxt_win_s     = {window_r[PAT_W-2:0], seq_in};
        pattern_nxt_s = pattern_r;
        window_nxt_s  = window_r;
        fill_nxt_s    = fill_r;
        if (fill_r == FILL_FULL) begin
            nfill_s = FILL_FULL;
        end else begin
            nfill_s = fill_r + FILL_W'(1);
        end
        hit_s = en & ~pat_load & (nfill_s == FILL_FULL) & (nxt_win_s == pattern_r);

        if (pat_load) begin
            // A load flushes the window and swallows this cycle's serial bit.
            pattern_nxt_s = pattern_in;
            window_nxt_s  = {PAT_W{1'b0}};
            fill_nxt_s    = {FILL_W{1'b0}};
        end else if (en) begin
            if (hit_s && !overlap_mode) begin
                window_nxt_s = {PAT_W{1'b0}};
                fill_nxt_s   = {FILL_W{1'b0}};
            end else begin
                window_nxt_s = nxt_win_s;
                fill_nxt_s   = nfill_s;
            end
        end else begin
            window_nxt_s = window_r;
            fill_nxt_s   = fill_r;
        end
    end

    // Counter: clear takes effect first so a coincident hit still counts.
    always_comb begin
        if (clr_cnt) begin
            cnt_base_s = {CNT_W{1'b0}};
        end else begin
            cnt_base_s = match_cnt_r;
        end
        if (hit_s && (cnt_base_s != CNT_MAX)) begin
            cnt_nxt_s = cnt_base_s + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_base_s;
        end
        cnt_sat_nxt_s = (cnt_nxt_s == CNT_MAX);
    end

    assign detected  = detected_r;
    assign match_cnt = match_cnt_r;
    assign cnt_sat   = cnt_sat_r;
    assign state_out = fill_r;

endmodule

// File: tb/tb_seq_det_param.sv
// Directed + random bench for seq_det_param; a bit-history model fills a scoreboard
// queue each cycle and the popped entry is compared after the clock edge.
module tb_seq_det_param;

    localparam int PAT_W = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       seq_in;
    logic       pat_load;
    logic [3:0] pattern_in;
    logic       overlap_mode;
    logic       clr_cnt;

    logic       det8, sat8, det2, sat2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic [2:0] fill8, fill2;

    always #5 clk = ~clk;

    seq_det_param #(.PAT_W(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .seq_in(seq_in), .pat_load(pat_load),
        .pattern_in(pattern_in), .overlap_mode(overlap_mode), .clr_cnt(clr_cnt),
        .detected(det8), .match_cnt(cnt8), .cnt_sat(sat8), .state_out(fill8)
    );

    seq_det_param #(.PAT_W(4), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .en(en), .seq_in(seq_in), .pat_load(pat_load),
        .pattern_in(pattern_in), .overlap_mode(overlap_mode), .clr_cnt(clr_cnt),
        .detected(det2), .match_cnt(cnt2), .cnt_sat(sat2), .state_out(fill2)
    );

    typedef struct packed {
        logic       det;
        logic [7:0] c8;
        logic       s8;
        logic [1:0] c2;
        logic       s2;
        logic [2:0] fill;
    } exp_t;

    exp_t       sb[$];
    bit         hist[$];
    logic [3:0] pat_m;
    int         c8_m, c2_m;
    int         n_pass = 0;
    int         n_total = 0;
    int         pulses = 0;
    logic       last_det = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        hist.delete();
        pat_m = 4'hF;
        c8_m  = 0;
        c2_m  = 0;
    endtask

    task automatic cyc();
        exp_t e;
        logic d;
        logic m;
        d = 1'b0;
        if (pat_load) begin
            pat_m = pattern_in;
            hist.delete();
        end else if (en) begin
            hist.push_back(seq_in);
            if (hist.size() > PAT_W) void'(hist.pop_front());
            if (hist.size() == PAT_W) begin
                m = 1'b1;
                for (int k = 0; k < PAT_W; k++)
                    if (hist[k] != pat_m[PAT_W-1-k]) m = 1'b0;
                d = m;
                if (d && !overlap_mode) hist.delete();
            end
        end
        if (clr_cnt) begin
            c8_m = 0;
            c2_m = 0;
        end
        if (d) begin
            if (c8_m < 255) c8_m++;
            if (c2_m < 3) c2_m++;
        end
        e.det  = d;
        e.c8   = 8'(c8_m);
        e.s8   = (c8_m == 255);
        e.c2   = 2'(c2_m);
        e.s2   = (c2_m == 3);
        e.fill = 3'(hist.size());
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("detected",   32'(det8),  32'(e.det));
        check("match_cnt",  32'(cnt8),  32'(e.c8));
        check("cnt_sat",    32'(sat8),  32'(e.s8));
        check("state_out",  32'(fill8), 32'(e.fill));
        check("detected2",  32'(det2),  32'(e.det));
        check("match_cnt2", 32'(cnt2),  32'(e.c2));
        check("cnt_sat2",   32'(sat2),  32'(e.s2));
        check("state_out2", 32'(fill2), 32'(e.fill));
        if (det8) pulses++;
        last_det = det8;
    endtask

    task automatic bit_in(input logic b);
        en = 1'b1; seq_in = b; pat_load = 1'b0; clr_cnt = 1'b0;
        cyc();
    endtask

    task automatic load(input logic [3:0] p, input logic clr);
        en = 1'b1; seq_in = 1'b0; pat_load = 1'b1; pattern_in = p; clr_cnt = clr;
        cyc();
        pat_load = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic feed(input logic [6:0] bits, input int n);
        logic [6:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; seq_in = 1'b0; pat_load = 1'b0;
        pattern_in = 4'h0; overlap_mode = 1'b1; clr_cnt = 1'b0;
        model_reset();

        // 1: reset defaults, default pattern 1111
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_detected",  32'(det8),  32'd0);
        check("rst_match_cnt", 32'(cnt8),  32'd0);
        check("rst_cnt_sat",   32'(sat8),  32'd0);
        check("rst_state_out", 32'(fill8), 32'd0);
        feed(7'b0000111, 3);
        check("t1_no_early", 32'(pulses), 32'd0);
        bit_in(1'b1);
        check("t1_pulse4", 32'(last_det), 32'd1);

        // 2: pattern 1011, overlapping then non-overlapping
        overlap_mode = 1'b1;
        load(4'b1011, 1'b1);
        pulses = 0;
        feed(7'b0001011, 4);
        check("t2o_hit4", 32'(last_det), 32'd1);
        feed(7'b0000011, 3);
        check("t2o_hit7", 32'(last_det), 32'd1);
        check("t2o_pulses", 32'(pulses), 32'd2);
        check("t2o_cnt", 32'(cnt8), 32'd2);
        overlap_mode = 1'b0;
        load(4'b1011, 1'b1);
        pulses = 0;
        feed(7'b1011011, 7);
        check("t2n_pulses", 32'(pulses), 32'd1);
        check("t2n_cnt", 32'(cnt8), 32'd1);
        check("t2n_fill", 32'(fill8), 32'd3);

        // 3: all-ones pattern
        overlap_mode = 1'b1;
        load(4'b1111, 1'b1);
        pulses = 0;
        feed(7'b1111111, 7);
        check("t3o_pulses", 32'(pulses), 32'd4);
        overlap_mode = 1'b0;
        load(4'b1111, 1'b1);
        pulses = 0;
        feed(7'b1111111, 7);
        check("t3n_pulses", 32'(pulses), 32'd1);
        check("t3n_fill", 32'(fill8), 32'd3);

        // 4: enable gating and mid-stream load
        load(4'b1011, 1'b1);
        feed(7'b0000010, 2);
        for (int i = 0; i < 2; i++) begin
            en = 1'b0; seq_in = i[0];
            cyc();
            check("t4_fill_held", 32'(fill8), 32'd2);
        end
        feed(7'b0000011, 2);
        check("t4_gap_hit", 32'(last_det), 32'd1);
        feed(7'b0000101, 3);
        load(4'b1011, 1'b0);
        check("t4_load_fill", 32'(fill8), 32'd0);
        bit_in(1'b1);
        check("t4_no_hit", 32'(last_det), 32'd0);

        // 5: saturation on the 2-bit counter, clear coinciding with a hit
        overlap_mode = 1'b1;
        load(4'b1111, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            bit_in(1'b1);
            if (i == 6) begin
                check("t5_cnt_at3", 32'(cnt2), 32'd3);
                check("t5_sat_at3", 32'(sat2), 32'd1);
            end
        end
        check("t5_cnt_hold", 32'(cnt2), 32'd3);
        check("t5_cnt8", 32'(cnt8), 32'd7);
        en = 1'b1; seq_in = 1'b1; clr_cnt = 1'b1;
        cyc();
        clr_cnt = 1'b0;
        check("t5_clr_hit_cnt", 32'(cnt2), 32'd1);
        check("t5_clr_hit_sat", 32'(sat2), 32'd0);

        // 6: async reset between edges, then random run
        load(4'b1011, 1'b0);
        feed(7'b0000101, 3);
        rst = 1'b1;
        #1;
        check("t6_rst_det",  32'(det8),  32'd0);
        check("t6_rst_cnt",  32'(cnt8),  32'd0);
        check("t6_rst_sat",  32'(sat8),  32'd0);
        check("t6_rst_fill", 32'(fill8), 32'd0);
        #2 rst = 1'b0;
        model_reset();
        bit_in(1'b1);
        check("t6_no_hit", 32'(last_det), 32'd0);

        load(4'b1011, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (i == 100) load(4'($urandom_range(0, 15)), 1'b0);
            overlap_mode = ((i / 50) % 2) == 0;
            en = ($urandom_range(0, 7) != 0);
            seq_in = 1'($urandom_range(0, 1));
            clr_cnt = ($urandom_range(0, 31) == 0);
            pat_load = 1'b0;
            cyc();
        end
        clr_cnt = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
Parametrised serial pattern detector. This is the next generation of the fixed-pattern, non-overlapping detector. It adds:
- PAT_W-bit pattern, loadable at run time
- Runtime-selectable overlapping or non-overlapping detection
- Sample-enable input
- Saturating match counter with synchronous clear

It sits on a 1-bit serial stream after the input synchroniser and feeds status/interrupt logic.

Parameters:
PAT_W, 4, pattern length in bits (legal range 2..16)
CNT_W, 8, width of match counter (legal range 2..32)
FILL_W, $clog2(PAT_W+1), width of fill-level output (derived; do not override)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
en  in  1  sample enable; seq_in sampled only when high
seq_in  in  1  serial data bit
pat_load  in  1  load pattern_in into pattern register, flush window
pattern_in  in  PAT_W  new pattern; bit PAT_W-1 is the first bit in time
overlap_mode  in  1  1 = overlapping detection, 0 = non-overlapping
clr_cnt  in  1  synchronous clear of match_cnt/cnt_sat
detected  out  1  one-cycle registered detection pulse
match_cnt  out  CNT_W  number of detections, saturating
cnt_sat  out  1  high once match_cnt reaches all-ones
state_out  out  FILL_W  current fill level (number of valid bits in window, 0..PAT_W)

Behaviour:
- Reset (async assert, sync deassert by upstream) forces:
  - pattern register = {PAT_W{1'b1}}, window = 0, fill = 0
  - detected = 0, match_cnt = 0, cnt_sat = 0
- Window shifts as window <= {window[PAT_W-2:0], seq_in}, newest bit at LSB.
- Fill increments on each sampled bit and saturates at PAT_W.
- Sample cycle (en=1, pat_load=0):
  - Let nxt = {window[PAT_W-2:0], seq_in} and nfill = min(fill+1, PAT_W).
  - Hit when nfill == PAT_W and nxt == pattern register.
- Hit response:
  - detected = 1 on the clock edge that samples the last pattern bit, i.e. visible the cycle after that bit is presented.
  - detected is 0 on every other edge.
- Overlapping (overlap_mode=1): after a hit, window and fill are kept (fill stays PAT_W). A hit is possible on every following sample.
- Non-overlapping (overlap_mode=0): after a hit, fill is set to 0 and window to 0. The next hit needs PAT_W fresh bits.
- overlap_mode is read at each sample edge. Changing it mid-stream takes effect from the next sample and never flushes the window.
- en=0:
  - window, fill and pattern hold; seq_in is ignored; detected = 0.
  - clr_cnt and pat_load still act.
- pat_load=1 (any en): pattern register <= pattern_in, window = 0, fill = 0, detected = 0. The bit on seq_in that cycle is discarded.
- Counter:
  - On a hit, match_cnt increments unless it is already all-ones; there it holds.
  - cnt_sat = 1 when match_cnt is all-ones.
- clr_cnt=1: match_cnt and cnt_sat are cleared.
  - If a hit occurs in the same cycle, clear applies first and then the increment, so match_cnt = 1 and cnt_sat = 0. No event is lost.
- state_out = fill, registered.
- Reset mid-stream: all state is lost immediately. After rst falls, detection needs PAT_W new bits.
- Implementation: no combinational path from inputs to outputs. All outputs are registered.

Test Plan:
1. Reset and defaults. Hold rst 3 cycles, then release.
   - Required: detected=0, match_cnt=0, cnt_sat=0, state_out=0.
   - Feed 1,1,1,1: detected pulses on the 4th edge (default pattern 1111).
2. Overlap vs non-overlap, PAT_W=4. pat_load with 4'b1011, then feed 1,0,1,1,0,1,1.
   - overlap_mode=1: detected after bits 4 and 7; match_cnt=2.
   - Repeat with overlap_mode=0: detected after bit 4 only; match_cnt=1; state_out=3 at end.
3. All-ones pattern. Pattern 1111, seven consecutive 1s.
   - overlap_mode=1: 4 pulses, after bits 4..7.
   - overlap_mode=0: 1 pulse, after bit 4; state_out=3 at end.
4. Enable gating and mid-stream load.
   - Feed 1,0 with en=1, then 2 cycles en=0 with seq_in toggling, then 1,1 with en=1: detected pulse (pattern 1011); state_out held at 2 during gap.
   - Assert pat_load after 1,0,1: state_out=0, and the following 1 produces no hit.
5. Counter saturation and clear, CNT_W=2, overlap_mode=1, pattern 1111, ten 1s.
   - match_cnt=3 and cnt_sat=1 after 3rd hit; match_cnt stays 3 afterwards.
   - clr_cnt in the same cycle as a hit: match_cnt=1, cnt_sat=0.
6. Async reset mid-stream and random run.
   - Assert rst between edges after 1,0,1: all outputs 0 immediately, no pulse for the following 1.
   - Then 200 $random bits vs behavioural model: detected and match_cnt match every cycle in both modes.
